// File: rtl/uart_tx_mmio_if.sv
// CPU data-bus view of the UART window: address/write strobe in, registered
// read data and window-select back to the top-level mux.
interface uart_tx_mmio_if;
  logic [15:0] address;
  logic [7:0]  data_write;
  logic        read_write;
  logic [7:0]  io_data_read;
  logic        io_sel;

  modport master (
    output address, data_write, read_write,
    input  io_data_read, io_sel
  );

  modport slave (
    input  address, data_write, read_write,
    output io_data_read, io_sel
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: two-byte register window (DATA, STATUS),
// byte FIFO, and a bit-serialiser with registered tx/tx_busy.
module uart_tx_mmio #(
  parameter logic [15:0] BASE_ADDR = 16'hD000,
  parameter int          CLK_DIV   = 434,
  parameter int          FIFO_AW   = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_mmio_if.slave  bus,
  output logic           tx,
  output logic           tx_busy
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(DEPTH);
  localparam logic [15:0] DIV_END = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic               hit, off, wr_data, wr_stat;
  logic               push, pop, full, empty, baud_end;
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [7:0]         mem_q [DEPTH];
  logic               ovf_q;
  state_t             state_q;
  logic [15:0]        baud_q;
  logic [2:0]         idx_q;
  logic [7:0]         shift_q;
  logic               tx_q, busy_q;
  logic [7:0]         rd_q;
  logic               sel_q;

  assign hit      = (bus.address[15:1] == BASE_ADDR[15:1]);
  assign off      = bus.address[0];
  assign wr_data  = hit && bus.read_write && !off;
  assign wr_stat  = hit && bus.read_write && off;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign baud_end = (baud_q == DIV_END);

  // Push decision uses the count at cycle start, so a pop in the same cycle
  // never makes room for a write that arrives while full.
  assign push = wr_data && !full;
  assign pop  = !empty && ((state_q == IDLE) || (state_q == STOP && baud_end));

  // Occupancy next-state; push and pop together cancel.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset since pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.data_write;
  end

  // FIFO pointers, count and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (wr_data && full)                      ovf_q <= 1'b1;
      else if (wr_stat && bus.data_write[3])    ovf_q <= 1'b0;
    end
  end

  // Transmit FSM: start, 8 data bits LSB first, stop; back-to-back frames
  // chain straight from STOP into START when another byte is queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            baud_q  <= '0;
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (baud_end) begin
            baud_q  <= '0;
            idx_q   <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              shift_q <= shift_q >> 1;
              idx_q   <= idx_q + 1'b1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= mem_q[rd_ptr_q];
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read path: one-cycle latency to match the synchronous RAM beside us.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= 8'h00;
      sel_q <= 1'b0;
    end else begin
      sel_q <= hit;
      rd_q  <= (hit && off) ? {4'b0, ovf_q, busy_q, empty, full} : 8'h00;
    end
  end

  assign bus.io_data_read = rd_q;
  assign bus.io_sel       = sel_q;
  assign tx               = tx_q;
  assign tx_busy          = busy_q;
endmodule
